// File: rtl/event_bus_queue.sv
// Multi-channel event collector. Each channel has a one-entry holding slot, and a
// round-robin arbiter drains the slots into a shared FIFO with a valid/ready output.
module event_bus_lane #(
  parameter int pDATA_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_i,
  input  logic                   pulse,
  input  logic                   grant,
  input  logic [pDATA_WIDTH-1:0] data,
  output logic                   pend,
  output logic [pDATA_WIDTH-1:0] hold,
  output logic                   drop
);
  // A slot that is being granted this cycle can take a new event immediately.
  assign drop = pulse & pend & ~grant;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      pend <= 1'b0;
      hold <= '0;
    end else if (pulse && (!pend || grant)) begin
      pend <= 1'b1;
      hold <= data;
    end else if (grant) begin
      pend <= 1'b0;
    end
  end
endmodule

module event_bus_queue #(
  parameter int pDATA_WIDTH     = 8,
  parameter int pCHANNELS       = 2,
  parameter int pDEPTH          = 4,
  parameter int pDROP_CNT_WIDTH = 8,
  localparam int CW = (pCHANNELS > 1) ? $clog2(pCHANNELS) : 1,
  localparam int FW = $clog2(pDEPTH) + 1
) (
  input  logic                             clk,
  input  logic                             reset_i,
  input  logic [pCHANNELS-1:0]             in_pulse,
  input  logic [pCHANNELS*pDATA_WIDTH-1:0] in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [pDATA_WIDTH-1:0]           out_data,
  output logic [CW-1:0]                    out_chan,
  output logic [FW-1:0]                    fill,
  output logic                             overflow,
  output logic [pDROP_CNT_WIDTH-1:0]       drop_count,
  input  logic                             clear_i
);
  localparam int AW = $clog2(pDEPTH);
  // Wide enough to hold a saturated count plus drops from all 16 possible channels.
  localparam int DW = pDROP_CNT_WIDTH + 5;
  localparam logic [DW-1:0] SAT = (DW'(1) << pDROP_CNT_WIDTH) - DW'(1);

  logic [pCHANNELS-1:0]                  pend, grant, drop;
  logic [pCHANNELS-1:0][pDATA_WIDTH-1:0] hold;
  logic [CW-1:0]                         last_grant, grant_idx;
  logic                                  grant_any, pop, can_write;
  logic [AW-1:0]                         wptr, rptr;
  logic [pDATA_WIDTH-1:0]                mem_data [pDEPTH];
  logic [CW-1:0]                         mem_chan [pDEPTH];
  logic [DW-1:0]                         ndrop, base, sum;

  for (genvar k = 0; k < pCHANNELS; k++) begin : g_lane
    event_bus_lane #(.pDATA_WIDTH(pDATA_WIDTH)) u_lane (
      .clk    (clk),
      .reset_i(reset_i),
      .pulse  (in_pulse[k]),
      .grant  (grant[k]),
      .data   (in_data[k*pDATA_WIDTH +: pDATA_WIDTH]),
      .pend   (pend[k]),
      .hold   (hold[k]),
      .drop   (drop[k])
    );
  end

  assign out_valid = (fill != '0);
  assign pop       = out_valid & out_ready;
  assign can_write = (fill != FW'(pDEPTH)) | pop;
  assign out_data  = mem_data[rptr];
  assign out_chan  = mem_chan[rptr];

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    int            idx;
    logic [CW-1:0] idx_c;
    idx       = 0;
    idx_c     = '0;
    grant     = '0;
    grant_idx = last_grant;
    grant_any = 1'b0;
    for (int i = 1; i <= pCHANNELS; i++) begin
      idx = int'(last_grant) + i;
      if (idx >= pCHANNELS) idx = idx - pCHANNELS;
      idx_c = CW'(idx);
      if (!grant_any && can_write && pend[idx_c]) begin
        grant_any = 1'b1;
        grant_idx = idx_c;
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  always_comb begin
    ndrop = '0;
    for (int k = 0; k < pCHANNELS; k++) ndrop = ndrop + DW'(drop[k]);
    base = clear_i ? '0 : DW'(drop_count);
    sum  = base + ndrop;
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      wptr       <= '0;
      rptr       <= '0;
      fill       <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
      last_grant <= CW'(pCHANNELS - 1);
      for (int i = 0; i < pDEPTH; i++) begin
        mem_data[i] <= '0;
        mem_chan[i] <= '0;
      end
    end else begin
      if (grant_any) begin
        mem_data[wptr] <= hold[grant_idx];
        mem_chan[wptr] <= grant_idx;
        wptr           <= wptr + AW'(1);
        last_grant     <= grant_idx;
      end
      if (pop) rptr <= rptr + AW'(1);
      case ({grant_any, pop})
        2'b10:   fill <= fill + FW'(1);
        2'b01:   fill <= fill - FW'(1);
        default: fill <= fill;
      endcase
      // A drop in the same cycle as a clear still leaves its mark.
      overflow   <= (overflow & ~clear_i) | (ndrop != '0);
      drop_count <= (sum > SAT) ? SAT[pDROP_CNT_WIDTH-1:0] : sum[pDROP_CNT_WIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_event_bus_queue.sv
// Self-checking bench for event_bus_queue: table vectors, directed corner sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_event_bus_queue;
  localparam int C = 2, W = 8, D = 4;

  logic           clk = 1'b0;
  logic           reset_i = 1'b1;
  logic [C-1:0]   in_pulse = '0;
  logic [C*W-1:0] in_data = '0;
  logic           out_valid, out_ready = 1'b0, out_chan, overflow, clear_i = 1'b0;
  logic [W-1:0]   out_data;
  logic [2:0]     fill;
  logic [7:0]     drop_count;

  int vecs = 0, errs = 0;

  event_bus_queue #(.pDATA_WIDTH(W), .pCHANNELS(C), .pDEPTH(D), .pDROP_CNT_WIDTH(8)) dut (
    .clk(clk), .reset_i(reset_i), .in_pulse(in_pulse), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_chan(out_chan),
    .fill(fill), .overflow(overflow), .drop_count(drop_count), .clear_i(clear_i)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: pending slots, a queue for the FIFO, counters as plain ints.
  typedef struct { int ch; logic [7:0] d; } ent_t;
  ent_t       mq[$];
  bit         m_pend[C];
  logic [7:0] m_hold[C];
  int         m_last, m_drop;
  bit         m_ovf;

  task automatic m_reset();
    mq.delete();
    for (int k = 0; k < C; k++) begin m_pend[k] = 0; m_hold[k] = '0; end
    m_last = C - 1; m_drop = 0; m_ovf = 0;
  endtask

  task automatic m_step(input logic [C-1:0] p, input logic [C*W-1:0] d, input bit r, input bit c);
    bit   pop;
    int   g, nd;
    ent_t e;
    pop = (mq.size() > 0) && r;
    g = -1;
    if (mq.size() < D || pop)
      for (int i = 1; i <= C; i++) begin
        int k = (m_last + i) % C;
        if (g < 0 && m_pend[k]) g = k;
      end
    if (pop) void'(mq.pop_front());
    if (g >= 0) begin
      e.ch = g; e.d = m_hold[g];
      mq.push_back(e);
      m_last = g; m_pend[g] = 0;
    end
    nd = 0;
    for (int k = 0; k < C; k++)
      if (p[k]) begin
        if (!m_pend[k]) begin m_pend[k] = 1; m_hold[k] = d[k*W +: W]; end
        else nd++;
      end
    m_drop = (c ? 0 : m_drop) + nd;
    if (m_drop > 255) m_drop = 255;
    m_ovf = (c ? 1'b0 : m_ovf) | (nd > 0);
  endtask

  task automatic m_cmp();
    chk("model_valid", out_valid, mq.size() > 0);
    chk("model_fill", fill, mq.size());
    chk("model_overflow", overflow, m_ovf);
    chk("model_drop_count", drop_count, m_drop);
    if (mq.size() > 0) begin
      chk("model_data", out_data, mq[0].d);
      chk("model_chan", out_chan, mq[0].ch);
    end
  endtask

  task automatic step(input logic [C-1:0] p, input logic [C*W-1:0] d, input bit r, input bit c);
    @(negedge clk);
    in_pulse = p; in_data = d; out_ready = r; clear_i = c;
    m_step(p, d, r, c);
    @(posedge clk);
    #1;
    m_cmp();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_i = 1; in_pulse = '0; out_ready = 0; clear_i = 0;
    m_reset();
    @(negedge clk);
    reset_i = 0;
  endtask

  typedef struct {
    bit         rst;
    logic [1:0] p;
    logic [15:0] d;
    bit         r;
    bit         e_v;
    logic [7:0] e_d;
    logic       e_c;
    int         e_fill;
  } vec_t;
  vec_t tv[9];

  logic [7:0] got[$];

  initial begin
    tv[0] = '{1, 2'b01, 16'h00A5, 1, 0, 8'h00, 1'b0, 0};
    tv[1] = '{0, 2'b00, 16'h0000, 1, 1, 8'hA5, 1'b0, 1};
    tv[2] = '{0, 2'b00, 16'h0000, 1, 0, 8'h00, 1'b0, 0};
    tv[3] = '{1, 2'b11, 16'h2211, 1, 0, 8'h00, 1'b0, 0};
    tv[4] = '{0, 2'b00, 16'h0000, 1, 1, 8'h11, 1'b0, 1};
    tv[5] = '{0, 2'b00, 16'h0000, 1, 1, 8'h22, 1'b1, 1};
    tv[6] = '{0, 2'b00, 16'h0000, 1, 0, 8'h00, 1'b0, 0};
    tv[7] = '{1, 2'b10, 16'h3300, 0, 0, 8'h00, 1'b0, 0};
    tv[8] = '{0, 2'b10, 16'h4400, 0, 1, 8'h33, 1'b1, 1};

    m_reset();
    repeat (2) @(negedge clk);
    chk("reset_valid", out_valid, 0);
    chk("reset_fill", fill, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_drop_count", drop_count, 0);
    reset_i = 0;

    // Single event, simultaneous events, pulse into a slot being granted.
    for (int i = 0; i < 9; i++) begin
      if (tv[i].rst) do_reset();
      step(tv[i].p, tv[i].d, tv[i].r, 0);
      chk("tv_valid", out_valid, tv[i].e_v);
      chk("tv_fill", fill, tv[i].e_fill);
      chk("tv_drop", drop_count, 0);
      if (tv[i].e_v) begin
        chk("tv_data", out_data, tv[i].e_d);
        chk("tv_chan", out_chan, tv[i].e_c);
      end
    end

    // Overflow: six back-to-back events into a stalled 4-deep queue.
    do_reset();
    for (int i = 1; i <= 6; i++) step(2'b01, {8'h00, 8'(i)}, 0, 0);
    chk("ovf_fill", fill, 4);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drop", drop_count, 1);
    got.delete();
    for (int i = 0; i < 8; i++) begin
      if (out_valid) got.push_back(out_data);
      step(2'b00, '0, 1, 0);
    end
    chk("ovf_drain_count", got.size(), 5);
    for (int i = 0; i < got.size(); i++) chk("ovf_drain_data", got[i], i + 1);
    chk("ovf_drain_empty", out_valid, 0);

    // Full queue with a same-cycle pop admits the pending event.
    do_reset();
    for (int i = 1; i <= 4; i++) step(2'b01, {8'h00, 8'(i)}, 0, 0);
    step(2'b00, '0, 0, 0);
    step(2'b10, 16'h7700, 0, 0);
    chk("full_pend_set", dut.pend[1], 1);
    step(2'b00, '0, 1, 0);
    chk("full_pop_fill", fill, 4);
    chk("full_pop_pend", dut.pend[1], 0);
    chk("full_pop_head", out_data, 8'h02);

    // Round-robin under contention: channels re-pulse as soon as their slot frees.
    do_reset();
    for (int i = 1; i <= 4; i++) step(2'b01, {8'h00, 8'(i)}, 0, 0);
    step(2'b00, '0, 0, 0);
    step(2'b11, 16'h8080, 0, 0);
    got.delete();
    for (int j = 0; j < 8; j++) begin
      logic [1:0] p;
      bit         r;
      r = (j % 2 == 0);
      p = {~m_pend[1], ~m_pend[0]};
      if (r && out_valid) got.push_back(8'(out_chan));
      step(p, {8'(j), 8'(j + 8'h40)}, r, 0);
    end
    for (int j = 0; j < 12; j++) begin
      if (out_valid) got.push_back(8'(out_chan));
      step(2'b00, '0, 1, 0);
    end
    chk("rr_count", got.size(), 10);
    for (int i = 0; i < got.size(); i++)
      chk("rr_chan", got[i], (i < 4) ? 0 : (((i - 4) % 2 == 0) ? 1 : 0));

    // Saturating drop counter, clear racing a drop, async reset mid-stream.
    do_reset();
    for (int i = 1; i <= 4; i++) step(2'b01, {8'h00, 8'(i)}, 0, 0);
    step(2'b11, 16'h9090, 0, 0);
    for (int i = 0; i < 150; i++) step(2'b11, 16'hEEEE, 0, 0);
    chk("sat_drop", drop_count, 255);
    chk("sat_ovf", overflow, 1);
    step(2'b01, 16'h00EE, 0, 1);
    chk("clr_drop_wins", drop_count, 1);
    chk("clr_drop_ovf", overflow, 1);
    step(2'b00, '0, 0, 1);
    chk("clr_drop", drop_count, 0);
    chk("clr_ovf", overflow, 0);

    do_reset();
    for (int i = 1; i <= 3; i++) step(2'b01, {8'h00, 8'(i)}, 0, 0);
    step(2'b00, '0, 0, 0);
    chk("rst_pre_fill", fill, 3);
    @(negedge clk);
    out_ready = 1;
    #2 reset_i = 1;
    #1;
    chk("rst_async_valid", out_valid, 0);
    chk("rst_async_fill", fill, 0);
    m_reset();
    @(negedge clk);
    reset_i = 0;
    for (int i = 0; i < 6; i++) begin
      step(2'b00, '0, 1, 0);
      chk("rst_no_emit", out_valid, 0);
    end

    // Randomized traffic: mostly-draining, then mostly-stalled to provoke drops.
    do_reset();
    for (int i = 0; i < 2400; i++) begin
      bit rdy;
      rdy = (i < 1200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      step(C'($urandom), (C*W)'($urandom), rdy, $urandom_range(0, 40) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
